// File: rtl/ifu_prefetch_pkg.sv
// Shared definitions for the instruction fetch stage.
package ifu_prefetch_pkg;

  localparam int unsigned CPU_WIDTH = 32;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] INST_NOP  = 32'h0000_0013;

  typedef enum logic [1:0] {
    IFU_IDLE  = 2'd0,
    IFU_FETCH = 2'd1,
    IFU_FLUSH = 2'd2
  } ifu_state_e;

endpackage

// File: rtl/ifu_inst_queue.sv
// Synchronous FIFO of {pc, inst} pairs with push/pop/flush and occupancy flags.
module ifu_inst_queue #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_pc,
  input  logic [WIDTH-1:0]             push_inst,
  input  logic                         pop,
  input  logic                         flush,
  output logic [WIDTH-1:0]             head_pc,
  output logic [WIDTH-1:0]             head_inst,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] pc_mem_q   [DEPTH];
  logic [WIDTH-1:0] inst_mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  // Next pointers and occupancy; flush discards everything, including a same-cycle push.
  always_comb begin
    full      = (count_q == CW'(DEPTH));
    empty     = (count_q == '0);
    do_pop    = pop && !flush && !empty;
    do_push   = push && !flush && (!full || do_pop);
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
    count     = count_q;
    head_pc   = pc_mem_q[rd_ptr_q];
    head_inst = inst_mem_q[rd_ptr_q];
  end

  // Pointer and count registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; needs no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      pc_mem_q[wr_ptr_q]   <= push_pc;
      inst_mem_q[wr_ptr_q] <= push_inst;
    end
  end

endmodule

// File: rtl/ifu_prefetch.sv
// Fetch stage: owns the fetch PC, issues in-order imem requests under a
// credit limit, queues responses with their PC, and flushes on redirect.
module ifu_prefetch #(
  parameter int unsigned          CPU_WIDTH       = ifu_prefetch_pkg::CPU_WIDTH,
  parameter logic [CPU_WIDTH-1:0] RESET_PC        = CPU_WIDTH'(ifu_prefetch_pkg::RESET_PC),
  parameter int unsigned          QUEUE_DEPTH     = 2,
  parameter int unsigned          MAX_OUTSTANDING = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  output logic                 ifu2imem_req_valid,
  output logic [CPU_WIDTH-1:0] ifu2imem_req_addr,
  input  logic                 imem2ifu_req_ready,
  input  logic                 imem2ifu_rsp_valid,
  input  logic [CPU_WIDTH-1:0] imem2ifu_rsp_inst,
  input  logic                 exu2ifu_redirect,
  input  logic [CPU_WIDTH-1:0] exu2ifu_target,
  output logic                 ifu2idu_en,
  output logic [CPU_WIDTH-1:0] ifu2idu_pc,
  output logic [CPU_WIDTH-1:0] ifu2idu_inst,
  input  logic                 idu2ifu_ready
);

  import ifu_prefetch_pkg::*;

  localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH + 1);
  localparam int unsigned SUM_W = CNT_W + 1;
  localparam logic [SUM_W-1:0] DEPTH_L   = SUM_W'(QUEUE_DEPTH);
  localparam logic [CNT_W-1:0] MAX_OUT_L = CNT_W'(MAX_OUTSTANDING);

  ifu_state_e           state_q, state_d;
  logic [CPU_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [CPU_WIDTH-1:0] resp_pc_q, resp_pc_d;
  logic [CNT_W-1:0]     out_q, out_d;
  logic [CNT_W-1:0]     drop_q, drop_d;

  logic [CPU_WIDTH-1:0] target_aligned;
  logic                 req_valid, accept, idu_en, pop, push;
  logic [CNT_W-1:0]     q_count;
  logic                 q_full, q_empty;
  logic [CPU_WIDTH-1:0] q_head_pc, q_head_inst;

  ifu_inst_queue #(
    .WIDTH (CPU_WIDTH),
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_pc   (resp_pc_q),
    .push_inst (imem2ifu_rsp_inst),
    .pop       (pop),
    .flush     (exu2ifu_redirect),
    .head_pc   (q_head_pc),
    .head_inst (q_head_inst),
    .count     (q_count),
    .full      (q_full),
    .empty     (q_empty)
  );

  // Request credits, response routing (keep or drop), redirect and output handshake.
  always_comb begin
    target_aligned = {exu2ifu_target[CPU_WIDTH-1:2], 2'b00};
    req_valid = (state_q != IFU_IDLE) && enable && !exu2ifu_redirect
             && (({1'b0, out_q} + {1'b0, q_count}) < DEPTH_L)
             && (out_q < MAX_OUT_L);
    accept     = req_valid && imem2ifu_req_ready;
    idu_en     = !q_empty && enable;
    pop        = idu_en && idu2ifu_ready;
    push       = 1'b0;
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    drop_d     = drop_q;
    out_d      = out_q + CNT_W'(accept) - CNT_W'(imem2ifu_rsp_valid);
    if (exu2ifu_redirect) begin
      fetch_pc_d = target_aligned;
      resp_pc_d  = target_aligned;
      drop_d     = out_q - CNT_W'(imem2ifu_rsp_valid);
    end else begin
      if (accept) fetch_pc_d = fetch_pc_q + CPU_WIDTH'(4);
      if (imem2ifu_rsp_valid) begin
        if (drop_q != '0) begin
          drop_d = drop_q - CNT_W'(1);
        end else begin
          push      = 1'b1;
          resp_pc_d = resp_pc_q + CPU_WIDTH'(4);
        end
      end
    end
    ifu2imem_req_valid = req_valid;
    ifu2imem_req_addr  = fetch_pc_q;
    ifu2idu_en         = idu_en;
    ifu2idu_pc         = q_empty ? '0 : q_head_pc;
    ifu2idu_inst       = q_empty ? '0 : q_head_inst;
  end

  // Next state: FLUSH whenever responses remain to be discarded.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IFU_IDLE: begin
        if (drop_d != '0)     state_d = IFU_FLUSH;
        else if (enable)      state_d = IFU_FETCH;
      end
      IFU_FETCH: begin
        if (exu2ifu_redirect && drop_d != '0) state_d = IFU_FLUSH;
        else if (!enable && drop_q == '0)     state_d = IFU_IDLE;
      end
      IFU_FLUSH: begin
        if (drop_d == '0) state_d = enable ? IFU_FETCH : IFU_IDLE;
      end
      default: state_d = IFU_IDLE;
    endcase
  end

  // State, PC and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IFU_IDLE;
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      out_q      <= '0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
    end
  end

endmodule

// File: tb/tb_ifu_prefetch.sv
// Self-checking bench for ifu_prefetch with an in-order memory model and a
// transaction-level reference (queue of {pc,inst}, credit counts).
`timescale 1ns/1ps
module tb_ifu_prefetch;
  import ifu_prefetch_pkg::*;

  localparam int QD   = 2;
  localparam int MOUT = 2;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, enable, req_valid, req_ready, rsp_valid, redirect, idu_en, idu_ready;
  logic [31:0] req_addr, rsp_inst, target, idu_pc, idu_inst;

  ifu_prefetch #(
    .CPU_WIDTH       (32),
    .RESET_PC        (32'h0000_0000),
    .QUEUE_DEPTH     (QD),
    .MAX_OUTSTANDING (MOUT)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .enable             (enable),
    .ifu2imem_req_valid (req_valid),
    .ifu2imem_req_addr  (req_addr),
    .imem2ifu_req_ready (req_ready),
    .imem2ifu_rsp_valid (rsp_valid),
    .imem2ifu_rsp_inst  (rsp_inst),
    .exu2ifu_redirect   (redirect),
    .exu2ifu_target     (target),
    .ifu2idu_en         (idu_en),
    .ifu2idu_pc         (idu_pc),
    .ifu2idu_inst       (idu_inst),
    .idu2ifu_ready      (idu_ready)
  );

  int total = 0;
  int bad   = 0;

  // Reference state
  logic [31:0] m_fetch, m_resp;
  logic [63:0] mq[$];
  logic [31:0] pend[$];
  int          m_out, m_drop;
  bit          m_active;
  bit          mem_hold, cmp_on;
  int          rsp_pct;
  bit          e_rv, e_en;
  logic [31:0] e_pc, e_inst;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return (a * 32'd2654435761) ^ INST_NOP;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_bound(input string name);
    total++;
    bad++;
    $display("FAIL %s: condition not reached within bound at %0t", name, $time);
  endtask

  task automatic model_reset();
    m_fetch = 32'h0; m_resp = 32'h0;
    mq.delete(); pend.delete();
    m_out = 0; m_drop = 0; m_active = 1'b0;
  endtask

  // Sample at the falling edge and compare every output with the reference.
  task automatic sample();
    @(negedge clk);
    e_rv   = m_active && enable && !redirect && (m_out + mq.size() < QD) && (m_out < MOUT);
    e_en   = (mq.size() != 0) && enable;
    e_pc   = (mq.size() != 0) ? mq[0][63:32] : 32'h0;
    e_inst = (mq.size() != 0) ? mq[0][31:0]  : 32'h0;
    if (cmp_on) begin
      chk("req_valid", 32'(req_valid), 32'(e_rv));
      chk("req_addr",  req_addr, m_fetch);
      chk("idu_en",    32'(idu_en), 32'(e_en));
      chk("idu_pc",    idu_pc, e_pc);
      chk("idu_inst",  idu_inst, e_inst);
      if (idu_en === 1'b1) chk("pc_inst_pair", idu_inst, inst_of(idu_pc));
    end
  endtask

  // Apply this cycle's events to the reference, then step the memory model.
  task automatic advance();
    bit acc, pop;
    acc = e_rv && req_ready;
    pop = e_en && idu_ready;
    if (rst) begin
      model_reset();
    end else begin
      if (acc) pend.push_back(m_fetch);
      if (redirect) begin
        m_drop  = m_out - (rsp_valid ? 1 : 0);
        mq.delete();
        m_fetch = target & ~32'h3;
        m_resp  = target & ~32'h3;
      end else begin
        if (pop) void'(mq.pop_front());
        if (rsp_valid) begin
          if (m_drop > 0) m_drop--;
          else begin
            mq.push_back({m_resp, rsp_inst});
            m_resp += 32'd4;
          end
        end
        if (acc) m_fetch += 32'd4;
      end
      m_out    = m_out + (acc ? 1 : 0) - (rsp_valid ? 1 : 0);
      m_active = enable || (m_drop > 0);
    end
    @(posedge clk);
    #1;
    if (pend.size() > 0 && !mem_hold && $urandom_range(99) < rsp_pct) begin
      rsp_valid = 1'b1;
      rsp_inst  = inst_of(pend.pop_front());
    end else begin
      rsp_valid = 1'b0;
      rsp_inst  = $urandom;
    end
  endtask

  task automatic tick();
    sample();
    advance();
  endtask

  task automatic do_reset();
    rst = 1'b1; enable = 1'b0; redirect = 1'b0; req_ready = 1'b0; idu_ready = 1'b0;
    mem_hold = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Wait for the first presented instruction and pin its pc.
  task automatic expect_first_pc(input string name, input logic [31:0] pc);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      sample();
      if (e_en) begin
        chk(name, idu_pc, pc);
        chk({name, "_inst"}, idu_inst, inst_of(pc));
        found = 1'b1;
        advance();
        break;
      end
      advance();
    end
    if (!found) fail_bound(name);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    rst = 1'b1; enable = 1'b0; req_ready = 1'b0; redirect = 1'b0; target = 32'h0;
    idu_ready = 1'b0; rsp_valid = 1'b0; rsp_inst = 32'h0; mem_hold = 1'b0; rsp_pct = 100;
    model_reset();
    cmp_on = 1'b0;
    @(posedge clk); #1;
    cmp_on = 1'b1;
    tick();
    rst = 1'b0;

    // Reset state
    sample();
    chk("rst_req_valid", 32'(req_valid), 32'h0);
    chk("rst_req_addr",  req_addr, 32'h0);
    chk("rst_en",        32'(idu_en), 32'h0);
    chk("rst_pc",        idu_pc, 32'h0);
    chk("rst_inst",      idu_inst, 32'h0);
    advance();

    // Streaming with ready memory and decoder
    enable = 1'b1; req_ready = 1'b1; idu_ready = 1'b1;
    sample(); chk("a_c0_rv", 32'(req_valid), 32'h0); advance();
    sample(); chk("a_c1_rv", 32'(req_valid), 32'h1); chk("a_c1_addr", req_addr, 32'h0); advance();
    sample(); chk("a_c2_en", 32'(idu_en), 32'h0); chk("a_c2_addr", req_addr, 32'h4); advance();
    sample(); chk("a_c3_en", 32'(idu_en), 32'h1); chk("a_c3_pc", idu_pc, 32'h0);
              chk("a_c3_inst", idu_inst, inst_of(32'h0)); advance();
    sample(); chk("a_c4_pc", idu_pc, 32'h4); advance();
    for (int i = 0; i < 10; i++) tick();

    // Decoder stalled: credits cap requests, then drain in order
    do_reset();
    enable = 1'b1; req_ready = 1'b1; idu_ready = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    sample(); chk("b_stall_rv", 32'(req_valid), 32'h0); chk("b_stall_pc", idu_pc, 32'h0); advance();
    idu_ready = 1'b1;
    sample(); chk("b_rel_pc0", idu_pc, 32'h0); advance();
    sample(); chk("b_rel_pc4", idu_pc, 32'h4); advance();
    for (int i = 0; i < 6; i++) tick();

    // Redirect with two responses in flight
    mem_hold = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (m_out == 2) begin found = 1'b1; break; end
      tick();
    end
    if (!found) fail_bound("c_two_outstanding");
    redirect = 1'b1; target = 32'h0000_0103;
    sample(); chk("c_redir_rv", 32'(req_valid), 32'h0); advance();
    redirect = 1'b0; mem_hold = 1'b0;
    sample(); chk("c_new_addr", req_addr, 32'h100); advance();
    expect_first_pc("c_first_pc", 32'h100);
    for (int i = 0; i < 4; i++) tick();

    // Redirect coinciding with a response and a pop
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (mq.size() > 0 && rsp_valid && enable && idu_ready) begin found = 1'b1; break; end
      tick();
    end
    if (!found) fail_bound("d_setup");
    redirect = 1'b1; target = 32'h0000_0040;
    sample(); chk("d_pop_en", 32'(idu_en), 32'h1); advance();
    redirect = 1'b0;
    sample(); chk("d_empty_en", 32'(idu_en), 32'h0); chk("d_addr", req_addr, 32'h40); advance();
    expect_first_pc("d_first_pc", 32'h40);

    // Enable low with one request outstanding
    do_reset();
    enable = 1'b1; req_ready = 1'b1; idu_ready = 1'b1; mem_hold = 1'b1;
    tick(); tick();
    enable = 1'b0; mem_hold = 1'b0;
    tick(); tick();
    sample(); chk("e_off_en", 32'(idu_en), 32'h0); chk("e_off_rv", 32'(req_valid), 32'h0); advance();
    tick();
    enable = 1'b1;
    sample(); chk("e_on_en", 32'(idu_en), 32'h1); chk("e_on_pc", idu_pc, 32'h0);
              chk("e_on_inst", idu_inst, inst_of(32'h0)); advance();
    for (int i = 0; i < 4; i++) tick();

    // Reset mid-stream with the queue full
    idu_ready = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (mq.size() == QD) begin found = 1'b1; break; end
      tick();
    end
    if (!found) fail_bound("f_queue_full");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sample(); chk("f_en", 32'(idu_en), 32'h0); chk("f_addr", req_addr, 32'h0);
              chk("f_rv", 32'(req_valid), 32'h0); advance();
    sample(); chk("f_restart_rv", 32'(req_valid), 32'h1); chk("f_restart_addr", req_addr, 32'h0); advance();

    // Randomized traffic
    rsp_pct = 60;
    for (int i = 0; i < 3000; i++) begin
      enable    = ($urandom_range(99) < 90);
      req_ready = ($urandom_range(99) < 70);
      idu_ready = ($urandom_range(99) < 70);
      redirect  = ($urandom_range(99) < 4);
      target    = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
      rst       = ($urandom_range(999) < 3);
      tick();
    end
    rst = 1'b0; redirect = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
